rs544522_enc_ctrl: RTL
======================

// Module: rs544522_enc_ctrl
// PURPOSE
//  Frame sequencer for the RS(544,522) L=7 matrix encoder core. Takes 522-symbol messages as 7-lane ready/valid beats.
//  Drives the core's start/valid/last/lane pins and zero-pads the leading lanes.
//  Forwards message beats as the systematic part of the codeword, then serialises the 22 parity symbols as extra beats.
//  Sits between the upstream symbol stream and the codeword output stream; the core is instantiated by the parent.
// PARAMETERS
//  W    10   symbol width, GF(2^10)
//  L    7    lanes per beat
//  K    522  message symbols per frame
//  R    22   parity symbols per frame
//  localparams (in package): NB=ceil(K/L)=75 msg beats, PAD=NB*L-K=3 leading zero lanes, NPB=ceil(R/L)=4 parity beats
// PORTS
//  clk_i               in   1      clock
//  rst_ni              in   1      async reset, active low
//  s_valid_i           in   1      upstream message beat valid
//  s_ready_o           out  1      upstream ready
//  s_data_i[0:L-1]     in   W each lane 0 = highest degree (MSB-first)
//  s_last_i            in   1      upstream end-of-message marker (checked only)
//  m_valid_o           out  1      codeword beat valid (registered)
//  m_ready_i           in   1      downstream ready
//  m_data_o[0:L-1]     out  W each codeword lanes
//  m_keep_o            out  L      bit j=1: lane j carries a real symbol
//  m_sop_o / m_last_o  out  1      first / last beat of codeword
//  enc_start_o, enc_valid_o, enc_last_o  out 1  core control (combinational from accept)
//  enc_data_o[0:L-1]   out  W each core lane inputs
//  enc_parity_valid_i  in   1      core parity strobe (1 cycle after enc_last_o)
//  enc_parity_i[0:R-1] in   W each core remainder, index i = coeff of x^i
//  err_len_o           out  1      1-cycle pulse: s_last_i disagrees with beat count
// BEHAVIOUR
//  Reset: state=MSG, beat_cnt=0, par_idx=0; m_valid_o/m_sop_o/m_last_o/err_len_o=0, m_data_o=0, m_keep_o=0, parity buffer=0.
//  Output register: one entry; free = !m_valid_o | m_ready_i.
//  MSG: s_ready_o = free. acc = s_valid_i & s_ready_o.
//   - enc_valid_o = acc; enc_start_o = acc & beat_cnt==0; enc_last_o = acc & beat_cnt==NB-1.
//   - enc_data_o = s_data_i, with lanes 0..PAD-1 forced to 0 when beat_cnt==0.
//   - On acc: output reg <= same data; keep = beat0 ? 7'b1111000 : all ones (bit j = lane j); sop = beat_cnt==0; last=0.
//   - beat_cnt++ on acc; at NB-1, acc wraps beat_cnt to 0 and goes to WAIT_PAR.
//  WAIT_PAR: s_ready_o=0. On enc_parity_valid_i, latch enc_parity_i into parity buffer and go to PAR.
//   - enc_parity_valid_i in any other state is ignored.
//  PAR: s_ready_o=0. When free, load parity beat p=par_idx: lane j = rem[R-1-(p*L+j)] if p*L+j<R, else 0 with keep bit 0.
//   - p=3 gives keep=7'b0000001 and m_last_o=1 (lane0=rem[0]).
//   - par_idx++; after loading p=NPB-1, par_idx=0 and go to MSG.
//   - Parity order is highest degree first (rem[21] first).
//  When free and nothing loads: m_valid_o drops to 0 and data is held.
//  Output beat holds stable while m_valid_o & !m_ready_i.
//  Frame length is counter-defined; s_last_i never ends a frame.
//   - err_len_o registered pulse the cycle after an acc where s_last_i != (beat_cnt==NB-1).
//  Throughput: NB+NPB=79 output beats per frame. Input stalls from the cycle after the last acc until parity beat 3 is loaded (min 5 cycles).
//  Reset mid-frame: everything returns to reset values; the next acc is treated as beat 0 (enc_start_o).
//   - The core's own reset is the parent's responsibility.
// STRUCTURE
//  Package rs544522_ctrl_pkg: W, L, K, R, NB, PAD, NPB, typedef sym_t=logic[W-1:0], enum ctrl_st_e {MSG, WAIT_PAR, PAR}.
//  Sub-module rs544522_par_serializer: parity buffer, par_idx counter, lane/keep/last mux for parity beats.
//  Top owns the FSM, beat counter, pad logic and output register.
// TESTING (bench has a behavioural RS(544,522) core model)
//  1 Zero message, m_ready=1, s_valid held:
//    - 75 accepts back-to-back; enc_start on beat 0 only, enc_last on beat 74.
//    - Parity all 0; 79 output beats, m_last on beat 78 with keep=7'h01.
//  2 Beat 0 all lanes 10'h3FF, other beats 0:
//    - enc_data lanes 0..2 = 0; m_keep beat 0 = 7'b1111000.
//    - Parity beats match the model remainder, rem[21] first.
//  3 m_ready pattern 1,0,1,0...:
//    - No lost or duplicated beats; enc_valid count = 75.
//    - Data stable while stalled; s_ready_o=0 whenever m_valid_o & !m_ready_i.
//  4 Two frames back-to-back:
//    - s_ready_o low from the cycle after frame-1 beat 74 until parity beat 3 loads.
//    - Frame 2 gets exactly one enc_start and m_sop.
//  5 s_last_i at beat 40 and not at 74:
//    - err_len_o pulses after beat 40 and after beat 74; frame still ends after 75 beats.
//  6 rst_ni low at beat 30 for 2 cycles:
//    - All outputs are reset values.
//    - The next accept gives enc_start_o=1 and m_sop_o=1.

Source files
------------

// File: rtl/rs544522_enc_ctrl_pkg.sv
// Shared types and frame geometry for the RS(544,522) L=7 encoder frame sequencer.
package rs544522_ctrl_pkg;

  localparam int unsigned W   = 10;
  localparam int unsigned L   = 7;
  localparam int unsigned K   = 522;
  localparam int unsigned R   = 22;
  localparam int unsigned NB  = (K + L - 1) / L;
  localparam int unsigned PAD = NB * L - K;
  localparam int unsigned NPB = (R + L - 1) / L;

  localparam int unsigned BW  = $clog2(NB);
  localparam int unsigned PW  = $clog2(NPB);
  localparam int unsigned LW  = $clog2(L);
  localparam int unsigned RW  = $clog2(R);

  typedef logic [W-1:0]     sym_t;
  typedef sym_t [L-1:0]     beat_t;
  typedef sym_t [R-1:0]     rem_t;
  typedef logic [L-1:0]     keep_t;

  typedef enum logic [1:0] {
    MSG      = 2'd0,
    WAIT_PAR = 2'd1,
    PAR      = 2'd2
  } ctrl_st_e;

  typedef struct packed {
    beat_t data;
    keep_t keep;
    logic  sop;
    logic  last;
  } out_beat_t;

  // Keep mask of the first message beat: leading pad lanes carry no symbol.
  localparam keep_t KEEP_FIRST = keep_t'({L{1'b1}} << PAD);

endpackage

// File: rtl/rs544522_enc_ctrl_if.sv
// Ready/valid beat stream, used for both the message input and the codeword output.
interface rs544522_enc_ctrl_if;
  import rs544522_ctrl_pkg::*;

  logic  valid;
  logic  ready;
  beat_t data;
  keep_t keep;
  logic  sop;
  logic  last;

  modport master (output valid, output data, output keep, output sop, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/rs544522_par_serializer.sv
// Holds the core remainder and slices it into L-lane parity beats, highest degree first.
module rs544522_par_serializer
  import rs544522_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  rem_t  rem_in,
  input  logic  adv,
  output beat_t data_c,
  output keep_t keep_c,
  output logic  last_c
);

  rem_t          rem_q;
  logic [PW-1:0] idx_q;

  assign last_c = (idx_q == PW'(NPB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      idx_q <= '0;
    end else begin
      if (load) begin
        rem_q <= rem_in;
      end
      if (adv) begin
        idx_q <= last_c ? '0 : idx_q + PW'(1);
      end
    end
  end

  // Lane j of beat p carries coefficient R-1-(p*L+j); lanes past the remainder are empty.
  always_comb begin
    int unsigned pos;
    data_c = '0;
    keep_c = '0;
    pos    = 0;
    for (int unsigned j = 0; j < L; j++) begin
      pos = 32'(idx_q) * L + j;
      if (pos < R) begin
        data_c[LW'(j)] = rem_q[RW'(R - 1 - pos)];
        keep_c[LW'(j)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs544522_enc_ctrl.sv
// Frame sequencer for the RS(544,522) matrix encoder core: feeds message beats to the
// core and the output stream, then appends the core's parity as extra beats.
module rs544522_enc_ctrl
  import rs544522_ctrl_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  rs544522_enc_ctrl_if.slave        s,
  rs544522_enc_ctrl_if.master       m,
  output logic                      enc_start_o,
  output logic                      enc_valid_o,
  output logic                      enc_last_o,
  output beat_t                     enc_data_o,
  input  logic                      enc_parity_valid_i,
  input  rem_t                      enc_parity_i,
  output logic                      err_len_o
);

  ctrl_st_e      st_q, st_d;
  logic [BW-1:0] beat_q;
  out_beat_t     out_q;
  logic          out_vld_q;
  logic          err_q;

  logic          free_c;
  logic          rdy_c;
  logic          acc_c;
  logic          first_c;
  logic          final_c;
  logic          par_load_c;
  logic          par_adv_c;
  beat_t         msg_data_c;
  beat_t         ser_data_c;
  keep_t         ser_keep_c;
  logic          ser_last_c;

  assign free_c  = !out_vld_q || m.ready;
  assign first_c = (beat_q == '0);
  assign final_c = (beat_q == BW'(NB - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q <= MSG;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d       = st_q;
    rdy_c      = 1'b0;
    acc_c      = 1'b0;
    par_load_c = 1'b0;
    par_adv_c  = 1'b0;
    unique case (st_q)
      MSG: begin
        rdy_c = free_c;
        acc_c = s.valid && free_c;
        if (acc_c && final_c) begin
          st_d = WAIT_PAR;
        end
      end
      WAIT_PAR: begin
        if (enc_parity_valid_i) begin
          par_load_c = 1'b1;
          st_d       = PAR;
        end
      end
      PAR: begin
        if (free_c) begin
          par_adv_c = 1'b1;
          if (ser_last_c) begin
            st_d = MSG;
          end
        end
      end
      default: st_d = MSG;
    endcase
  end

  // Leading lanes of the first beat are padding so the message fills NB whole beats.
  always_comb begin
    msg_data_c = s.data;
    if (first_c) begin
      for (int unsigned p = 0; p < PAD; p++) begin
        msg_data_c[LW'(p)] = '0;
      end
    end
  end

  assign s.ready     = rdy_c;
  assign enc_valid_o = acc_c;
  assign enc_start_o = acc_c && first_c;
  assign enc_last_o  = acc_c && final_c;
  assign enc_data_o  = msg_data_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= acc_c && (s.last != final_c);
      if (acc_c) begin
        beat_q <= final_c ? '0 : beat_q + BW'(1);
      end
    end
  end

  // Single-entry output register; contents hold until a new beat loads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else if (acc_c) begin
      out_vld_q  <= 1'b1;
      out_q.data <= msg_data_c;
      out_q.keep <= first_c ? KEEP_FIRST : '1;
      out_q.sop  <= first_c;
      out_q.last <= 1'b0;
    end else if (par_adv_c) begin
      out_vld_q  <= 1'b1;
      out_q.data <= ser_data_c;
      out_q.keep <= ser_keep_c;
      out_q.sop  <= 1'b0;
      out_q.last <= ser_last_c;
    end else if (free_c) begin
      out_vld_q <= 1'b0;
    end
  end

  rs544522_par_serializer u_ser (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .load   (par_load_c),
    .rem_in (enc_parity_i),
    .adv    (par_adv_c),
    .data_c (ser_data_c),
    .keep_c (ser_keep_c),
    .last_c (ser_last_c)
  );

  assign m.valid   = out_vld_q;
  assign m.data    = out_q.data;
  assign m.keep    = out_q.keep;
  assign m.sop     = out_q.sop;
  assign m.last    = out_q.last;
  assign err_len_o = err_q;

endmodule
